// File: rtl/maze_round_controller_if.sv
// Purpose: groups the round controller's game inputs and status outputs into one bundle.
//   master: the side that drives buttons/timer/maze and watches status (debouncer/top-level/bench).
//   slave : the round controller itself.
// Signals:
//   tick_10hz, btn_up/down/left/right/ctrl, pausesw   control inputs
//   maze_walls, start_row/col, goal_row/col          maze description
//   pos_row/col/idx, game_state, time_left, strikes  round status
//   bump, win, lose                                  event/result flags
interface maze_round_controller_if #(
  parameter int unsigned MAZE_W = 18,
  parameter int unsigned MAZE_H = 11
);
  logic                       tick_10hz;
  logic                       btn_up;
  logic                       btn_down;
  logic                       btn_left;
  logic                       btn_right;
  logic                       btn_ctrl;
  logic                       pausesw;
  logic [MAZE_W*MAZE_H-1:0]   maze_walls;
  logic [3:0]                 start_row;
  logic [4:0]                 start_col;
  logic [3:0]                 goal_row;
  logic [4:0]                 goal_col;
  logic [3:0]                 pos_row;
  logic [4:0]                 pos_col;
  logic [7:0]                 pos_idx;
  logic [2:0]                 game_state;
  logic [9:0]                 time_left;
  logic [1:0]                 strikes;
  logic                       bump;
  logic                       win;
  logic                       lose;

  modport master (
    output tick_10hz, btn_up, btn_down, btn_left, btn_right, btn_ctrl, pausesw,
    output maze_walls, start_row, start_col, goal_row, goal_col,
    input  pos_row, pos_col, pos_idx, game_state, time_left, strikes, bump, win, lose
  );

  modport slave (
    input  tick_10hz, btn_up, btn_down, btn_left, btn_right, btn_ctrl, pausesw,
    input  maze_walls, start_row, start_col, goal_row, goal_col,
    output pos_row, pos_col, pos_idx, game_state, time_left, strikes, bump, win, lose
  );
endinterface

// File: rtl/maze_round_controller.sv
// Purpose: runs one round of the maze defuse game - cursor movement against the wall
//   map, strike counting, round timer and WIN/LOSE decision.
// Ports:
//   CLK    system clock
//   RESET  asynchronous active-low reset
//   bus    maze_round_controller_if.slave (buttons, timer tick, maze in; cursor/status out)
module maze_round_controller #(
  parameter int unsigned MAZE_W      = 18,
  parameter int unsigned MAZE_H      = 11,
  parameter int unsigned TIME_LIMIT  = 600,
  parameter int unsigned MAX_STRIKES = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  maze_round_controller_if.slave  bus
);

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 5;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned TIME_W = 10;
  localparam int unsigned STK_W  = 2;
  localparam int unsigned NBTN   = 5;

  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(MAZE_H - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(MAZE_W - 1);
  localparam logic [TIME_W-1:0] TIME_INI = TIME_W'(TIME_LIMIT);
  localparam logic [STK_W-1:0]  STK_MAX  = STK_W'(MAX_STRIKES);

  // button vector bit positions; lower index wins direction arbitration
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_LEFT  = 2;
  localparam int unsigned B_RIGHT = 3;
  localparam int unsigned B_CTRL  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [ROW_W-1:0]  r_row,      w_row_nxt;
  logic [COL_W-1:0]  r_col,      w_col_nxt;
  logic [IDX_W-1:0]  r_idx,      w_idx_nxt;
  logic [TIME_W-1:0] r_time,     w_time_nxt;
  logic [STK_W-1:0]  r_strikes,  w_strikes_nxt;
  logic              r_bump,     w_bump_nxt;
  logic              r_win;
  logic              r_lose;
  logic [ROW_W-1:0]  r_goal_row, w_goal_row_nxt;
  logic [COL_W-1:0]  r_goal_col, w_goal_col_nxt;
  logic [NBTN-1:0]   r_btn_q;

  logic [NBTN-1:0]   w_btn;
  logic [NBTN-1:0]   w_press;
  logic              w_dir_valid;
  logic              w_edge;
  logic [ROW_W-1:0]  w_tgt_row;
  logic [COL_W-1:0]  w_tgt_col;
  logic [IDX_W-1:0]  w_tgt_idx;
  logic              w_wall;
  logic              w_won;
  logic              w_lost;

  assign w_btn   = {bus.btn_ctrl, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign w_press = w_btn & ~r_btn_q;

  // Pick the single winning direction and its target cell; edge flags moves off the grid.
  always_comb begin
    w_dir_valid = 1'b1;
    w_edge      = 1'b0;
    w_tgt_row   = r_row;
    w_tgt_col   = r_col;
    if (w_press[B_UP]) begin
      w_edge    = (r_row == '0);
      w_tgt_row = r_row - ROW_W'(1);
    end else if (w_press[B_DOWN]) begin
      w_edge    = (r_row == ROW_MAX);
      w_tgt_row = r_row + ROW_W'(1);
    end else if (w_press[B_LEFT]) begin
      w_edge    = (r_col == '0);
      w_tgt_col = r_col - COL_W'(1);
    end else if (w_press[B_RIGHT]) begin
      w_edge    = (r_col == COL_MAX);
      w_tgt_col = r_col + COL_W'(1);
    end else begin
      w_dir_valid = 1'b0;
    end
    w_tgt_idx = IDX_W'(w_tgt_row) * IDX_W'(MAZE_W) + IDX_W'(w_tgt_col);
    w_wall    = bus.maze_walls[w_tgt_idx];
  end

  // Round FSM next-state and datapath updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_time_nxt     = r_time;
    w_strikes_nxt  = r_strikes;
    w_bump_nxt     = 1'b0;
    w_goal_row_nxt = r_goal_row;
    w_goal_col_nxt = r_goal_col;
    w_won          = 1'b0;
    w_lost         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_press[B_CTRL]) begin
          w_state_nxt    = ST_PLAY;
          w_row_nxt      = (bus.start_row > ROW_MAX) ? ROW_MAX : bus.start_row;
          w_col_nxt      = (bus.start_col > COL_MAX) ? COL_MAX : bus.start_col;
          w_goal_row_nxt = bus.goal_row;
          w_goal_col_nxt = bus.goal_col;
          w_time_nxt     = TIME_INI;
          w_strikes_nxt  = '0;
        end
      end

      ST_PLAY: begin
        // pause swallows this cycle's presses and tick entirely
        if (bus.pausesw) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          if (w_dir_valid && !w_edge) begin
            if (w_wall) begin
              w_bump_nxt = 1'b1;
              if (r_strikes < STK_MAX) begin
                w_strikes_nxt = r_strikes + STK_W'(1);
              end
              w_lost = (w_strikes_nxt == STK_MAX);
            end else begin
              w_row_nxt = w_tgt_row;
              w_col_nxt = w_tgt_col;
              w_won     = (w_tgt_row == r_goal_row) && (w_tgt_col == r_goal_col);
            end
          end
          if (bus.tick_10hz && (r_time != '0)) begin
            w_time_nxt = r_time - TIME_W'(1);
            if (r_time == TIME_W'(1)) begin
              w_lost = 1'b1;
            end
          end
          // reaching the goal beats a simultaneous timer expiry
          if (w_won) begin
            w_state_nxt = ST_WIN;
          end else if (w_lost) begin
            w_state_nxt = ST_LOSE;
          end
        end
      end

      ST_PAUSE: begin
        if (!bus.pausesw) begin
          w_state_nxt = ST_PLAY;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (w_press[B_CTRL]) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_idx_nxt = IDX_W'(w_row_nxt) * IDX_W'(MAZE_W) + IDX_W'(w_col_nxt);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_idx      <= '0;
      r_time     <= TIME_INI;
      r_strikes  <= '0;
      r_bump     <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_goal_row <= '0;
      r_goal_col <= '0;
      r_btn_q    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_idx      <= w_idx_nxt;
      r_time     <= w_time_nxt;
      r_strikes  <= w_strikes_nxt;
      r_bump     <= w_bump_nxt;
      r_win      <= (w_state_nxt == ST_WIN);
      r_lose     <= (w_state_nxt == ST_LOSE);
      r_goal_row <= w_goal_row_nxt;
      r_goal_col <= w_goal_col_nxt;
      r_btn_q    <= w_btn;
    end
  end

  assign bus.pos_row    = r_row;
  assign bus.pos_col    = r_col;
  assign bus.pos_idx    = r_idx;
  assign bus.game_state = r_state;
  assign bus.time_left  = r_time;
  assign bus.strikes    = r_strikes;
  assign bus.bump       = r_bump;
  assign bus.win        = r_win;
  assign bus.lose       = r_lose;

endmodule

// File: tb/tb_maze_round_controller.sv
// Purpose: self-checking bench for maze_round_controller - directed round scenarios
//   followed by randomized play, all compared every cycle against a behavioural model.
module tb_maze_round_controller;

  localparam int unsigned MAZE_W      = 18;
  localparam int unsigned MAZE_H      = 11;
  localparam int unsigned TIME_LIMIT  = 600;
  localparam int unsigned MAX_STRIKES = 3;
  localparam int unsigned NCELL       = MAZE_W * MAZE_H;

  logic CLK;
  logic RESET;

  maze_round_controller_if #(.MAZE_W(MAZE_W), .MAZE_H(MAZE_H)) bus ();

  maze_round_controller #(
    .MAZE_W(MAZE_W), .MAZE_H(MAZE_H), .TIME_LIMIT(TIME_LIMIT), .MAX_STRIKES(MAX_STRIKES)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model: 0 IDLE, 1 PLAY, 2 PAUSE, 3 WIN, 4 LOSE
  int m_state, m_row, m_col, m_time, m_strikes, m_bump, m_goal_r, m_goal_c;
  bit m_prev [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_row = 0; m_col = 0; m_time = TIME_LIMIT; m_strikes = 0; m_bump = 0;
    m_goal_r = 0; m_goal_c = 0;
    for (int i = 0; i < 5; i++) m_prev[i] = 1'b0;
  endtask

  // One clock edge of the game rules, computed from the current input levels.
  task automatic model_step();
    bit btn [5];
    bit pr [5];
    int dr, dc, nr, nc;
    bit won, lost;
    btn[0] = bus.btn_up; btn[1] = bus.btn_down; btn[2] = bus.btn_left;
    btn[3] = bus.btn_right; btn[4] = bus.btn_ctrl;
    for (int i = 0; i < 5; i++) begin
      pr[i] = btn[i] && !m_prev[i];
      m_prev[i] = btn[i];
    end
    m_bump = 0;
    case (m_state)
      0: if (pr[4]) begin
        m_state = 1;
        m_row = (int'(bus.start_row) > int'(MAZE_H) - 1) ? int'(MAZE_H) - 1 : int'(bus.start_row);
        m_col = (int'(bus.start_col) > int'(MAZE_W) - 1) ? int'(MAZE_W) - 1 : int'(bus.start_col);
        m_goal_r = int'(bus.goal_row);
        m_goal_c = int'(bus.goal_col);
        m_time = TIME_LIMIT;
        m_strikes = 0;
      end
      1: if (bus.pausesw) begin
        m_state = 2;
      end else begin
        dr = 0; dc = 0; won = 0; lost = 0;
        if (pr[0]) dr = -1;
        else if (pr[1]) dr = 1;
        else if (pr[2]) dc = -1;
        else if (pr[3]) dc = 1;
        nr = m_row + dr;
        nc = m_col + dc;
        if ((dr != 0 || dc != 0) && nr >= 0 && nr < int'(MAZE_H) && nc >= 0 && nc < int'(MAZE_W)) begin
          if (bus.maze_walls[nr * int'(MAZE_W) + nc]) begin
            m_bump = 1;
            if (m_strikes < int'(MAX_STRIKES)) m_strikes++;
            if (m_strikes == int'(MAX_STRIKES)) lost = 1;
          end else begin
            m_row = nr;
            m_col = nc;
            won = (nr == m_goal_r) && (nc == m_goal_c);
          end
        end
        if (bus.tick_10hz && m_time > 0) begin
          if (m_time == 1) lost = 1;
          m_time--;
        end
        if (won) m_state = 3;
        else if (lost) m_state = 4;
      end
      2: if (!bus.pausesw) m_state = 1;
      3, 4: if (pr[4]) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic check_all();
    check("state",   32'(bus.game_state), 32'(m_state));
    check("row",     32'(bus.pos_row),    32'(m_row));
    check("col",     32'(bus.pos_col),    32'(m_col));
    check("idx",     32'(bus.pos_idx),    32'(m_row * int'(MAZE_W) + m_col));
    check("time",    32'(bus.time_left),  32'(m_time));
    check("strikes", 32'(bus.strikes),    32'(m_strikes));
    check("bump",    32'(bus.bump),       32'(m_bump));
    check("win",     32'(bus.win),        32'(m_state == 3));
    check("lose",    32'(bus.lose),       32'(m_state == 4));
  endtask

  // Inputs change only between edges; returns at the following falling edge after checking.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic set_btns(input bit [4:0] b);
    bus.btn_up = b[0]; bus.btn_down = b[1]; bus.btn_left = b[2];
    bus.btn_right = b[3]; bus.btn_ctrl = b[4];
  endtask

  task automatic press(input bit [4:0] b);
    set_btns(b);
    cycle();
    set_btns(5'b0);
    cycle();
  endtask

  // Asynchronous reset, asserted away from the clock edge and checked before any edge arrives.
  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic start_round(input int sr, input int sc, input int gr, input int gc);
    do_reset();
    bus.start_row = 4'(sr); bus.start_col = 5'(sc);
    bus.goal_row  = 4'(gr); bus.goal_col  = 5'(gc);
    press(5'b10000);
  endtask

  bit pause_lvl;

  initial begin
    RESET = 1'b0;
    set_btns(5'b0);
    bus.tick_10hz = 1'b0;
    bus.pausesw = 1'b0;
    bus.maze_walls = '0;
    bus.start_row = '0; bus.start_col = '0; bus.goal_row = '0; bus.goal_col = '0;
    @(negedge CLK);
    do_reset();

    // reset mid-round clears everything immediately
    start_round(5, 7, 10, 17);
    check("t1_play", 32'(bus.game_state), 32'd1);
    check("t1_pos",  32'(bus.pos_idx), 32'd97);
    repeat (3) cycle();
    #2;
    do_reset();
    check("t1_rst_state", 32'(bus.game_state), 32'd0);
    check("t1_rst_idx",   32'(bus.pos_idx),    32'd0);
    check("t1_rst_time",  32'(bus.time_left),  32'd600);
    check("t1_rst_strk",  32'(bus.strikes),    32'd0);
    press(5'b10000);
    check("t1_restart", 32'(bus.game_state), 32'd1);

    // plain moves with one-cycle latency; a held button moves once
    start_round(1, 1, 10, 17);
    for (int k = 0; k < 3; k++) begin
      set_btns(5'b01000);
      cycle();
      check("t2_latency", 32'(bus.pos_col), 32'(2 + k));
      set_btns(5'b0);
      cycle();
    end
    check("t2_col", 32'(bus.pos_col), 32'd4);
    check("t2_idx", 32'(bus.pos_idx), 32'd22);
    set_btns(5'b01000);
    repeat (10) cycle();
    set_btns(5'b0);
    cycle();
    check("t2_hold", 32'(bus.pos_col), 32'd5);

    // wall bumps accumulate strikes up to LOSE
    bus.maze_walls[20] = 1'b1;
    start_round(1, 1, 10, 17);
    for (int k = 1; k <= 3; k++) begin
      set_btns(5'b01000);
      cycle();
      check("t3_bump", 32'(bus.bump), 32'd1);
      check("t3_strk", 32'(bus.strikes), 32'(k));
      set_btns(5'b0);
      cycle();
      check("t3_bump_off", 32'(bus.bump), 32'd0);
    end
    check("t3_lose", 32'(bus.game_state), 32'd4);
    check("t3_pos",  32'(bus.pos_idx), 32'd19);
    bus.maze_walls = '0;

    // grid edges: no move, no bump; up outranks right
    start_round(0, 0, 10, 17);
    press(5'b00001);
    press(5'b00100);
    check("t4_idx",  32'(bus.pos_idx), 32'd0);
    check("t4_strk", 32'(bus.strikes), 32'd0);
    set_btns(5'b01001);
    cycle();
    check("t4_prio", 32'(bus.pos_col), 32'd0);
    check("t4_bump", 32'(bus.bump), 32'd0);
    set_btns(5'b0);
    cycle();

    // timer expiry coinciding with reaching the goal, then expiry alone
    start_round(1, 1, 1, 2);
    bus.tick_10hz = 1'b1;
    repeat (TIME_LIMIT - 1) cycle();
    bus.tick_10hz = 1'b0;
    cycle();
    check("t5_time1", 32'(bus.time_left), 32'd1);
    bus.tick_10hz = 1'b1;
    set_btns(5'b01000);
    cycle();
    bus.tick_10hz = 1'b0;
    set_btns(5'b0);
    check("t5_win",   32'(bus.game_state), 32'd3);
    check("t5_time0", 32'(bus.time_left), 32'd0);
    cycle();
    start_round(1, 1, 10, 17);
    bus.tick_10hz = 1'b1;
    repeat (TIME_LIMIT) cycle();
    bus.tick_10hz = 1'b0;
    check("t5_lose", 32'(bus.game_state), 32'd4);
    check("t5_time", 32'(bus.time_left), 32'd0);
    cycle();

    // pause freezes time and position
    start_round(1, 1, 10, 17);
    bus.tick_10hz = 1'b1;
    cycle();
    bus.pausesw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_btns((i < 10 && (i % 2) == 0) ? 5'b01000 : 5'b0);
      cycle();
    end
    bus.tick_10hz = 1'b0;
    set_btns(5'b0);
    check("t6_pause", 32'(bus.game_state), 32'd2);
    check("t6_time",  32'(bus.time_left), 32'd599);
    check("t6_pos",   32'(bus.pos_idx), 32'd19);
    bus.pausesw = 1'b0;
    cycle();
    check("t6_resume", 32'(bus.game_state), 32'd1);
    bus.tick_10hz = 1'b1;
    cycle();
    bus.tick_10hz = 1'b0;
    check("t6_tick", 32'(bus.time_left), 32'd598);

    // randomized play against the model
    pause_lvl = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if ((c % 300) == 0) begin
        for (int i = 0; i < int'(NCELL); i++) bus.maze_walls[i] = ($urandom_range(0, 3) == 0);
        bus.start_row = 4'($urandom_range(0, 15));
        bus.start_col = 5'($urandom_range(0, 31));
        bus.goal_row  = 4'($urandom_range(0, MAZE_H - 1));
        bus.goal_col  = 5'($urandom_range(0, MAZE_W - 1));
      end
      if ($urandom_range(0, 39) == 0) pause_lvl = ~pause_lvl;
      bus.pausesw   = pause_lvl;
      bus.tick_10hz = ($urandom_range(0, 2) == 0);
      bus.btn_up    = ($urandom_range(0, 3) == 0);
      bus.btn_down  = ($urandom_range(0, 3) == 0);
      bus.btn_left  = ($urandom_range(0, 3) == 0);
      bus.btn_right = ($urandom_range(0, 3) == 0);
      bus.btn_ctrl  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
